// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and sizing helpers for the truth-table sweeper
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int N_IN_DEF = 4;
    localparam int TT_W     = 2 ** N_IN_DEF;

    // Settle counter only needs to reach SETTLE-1; keep at least one bit so SETTLE=1 still elaborates.
    function automatic int settle_cnt_w(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - result handshake bundle between sweeper and consumer
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int W = 1 << N_IN;

    logic            result_valid;
    logic            result_ready;
    logic [W-1:0]    tt_captured;
    logic            match;
    logic [W-1:0]    mismatch_mask;
    logic [N_IN-1:0] first_fail;

    modport master (
        output result_valid,
        input  result_ready,
        output tt_captured,
        output match,
        output mismatch_mask,
        output first_fail
    );

    modport slave (
        input  result_valid,
        output result_ready,
        input  tt_captured,
        input  match,
        input  mismatch_mask,
        input  first_fail
    );
endinterface

// File: rtl/truth_table_sweeper_tt_first_diff.sv
// rtl/truth_table_sweeper_tt_first_diff.sv - lowest-set-bit priority encoder for mismatch masks
module tt_first_diff #(
    parameter int N_IN = 4
) (
    input  logic [(1<<N_IN)-1:0] vec,
    output logic [N_IN-1:0]      index,
    output logic                 any_set
);

    // Scan from the top down so the lowest set bit is the last one to win; index stays 0 when vec is 0.
    always_comb begin
        index   = '0;
        any_set = |vec;
        for (int i = (1 << N_IN) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = N_IN'(i);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors of a 4-input netlist and compares its truth table
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] expected,
    output logic [N_IN-1:0]      probe_in,
    input  logic                 probe_out,
    output logic                 busy,
    truth_table_sweeper_if.master res
);

    localparam int              W        = 1 << N_IN;
    localparam int              CW       = settle_cnt_w(SETTLE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(W - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    tt_q;
    logic [W-1:0]    exp_q;
    logic            rv_q;
    logic [W-1:0]    diff;
    logic [N_IN-1:0] low_idx;
    logic            any_diff;

    // Sweep sequencer: latch on start, hold each vector SETTLE cycles, capture, then park in REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            probe_in <= '0;
            idx      <= '0;
            cnt      <= '0;
            tt_q     <= '0;
            exp_q    <= '0;
            busy     <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    probe_in <= '0;
                    if (start) begin
                        exp_q <= expected;
                        tt_q  <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        tt_q[idx] <= probe_out;
                        cnt       <= '0;
                        if (idx == IDX_LAST) begin
                            busy  <= 1'b0;
                            rv_q  <= 1'b1;
                            state <= REPORT;
                        end else begin
                            idx      <= idx + 1'b1;
                            probe_in <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (rv_q && res.result_ready) begin
                        rv_q     <= 1'b0;
                        idx      <= '0;
                        probe_in <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Compare outputs are pure functions of the registered table and latched expectation.
    always_comb begin
        diff = tt_q ^ exp_q;
    end

    tt_first_diff #(.N_IN(N_IN)) u_first_diff (
        .vec     (diff),
        .index   (low_idx),
        .any_set (any_diff)
    );

    assign res.result_valid  = rv_q;
    assign res.tt_captured   = tt_q;
    assign res.mismatch_mask = diff;
    assign res.match         = ~any_diff;
    assign res.first_fail    = low_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench with behavioural truth-table model
module tb_truth_table_sweeper;
    import truth_table_sweeper_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] expected = '0;
    logic        sel = 1'b0;
    int          mode = 0;
    logic [15:0] rand_tt = '0;

    logic        start_a, start_b;
    logic [3:0]  pi_a, pi_b;
    logic        po_a, po_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    logic        sweep_on = 1'b0;
    int          j = 0;
    logic [15:0] m_tt, m_mask;
    logic [3:0]  m_ff;
    logic        m_match;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(4)) if_a ();
    truth_table_sweeper_if #(.N_IN(4)) if_b ();

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign if_a.result_ready = ready;
    assign if_b.result_ready = ready;

    function automatic logic stub(input int md, input logic [3:0] v, input logic [15:0] tbl);
        case (md)
            0:       return &v;
            1:       return v[0];
            2:       return 1'b1;
            3:       return v == 4'd5;
            default: return tbl[v];
        endcase
    endfunction

    function automatic logic [15:0] model_tt(input int md, input logic [15:0] tbl);
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = stub(md, 4'(v), tbl);
        return t;
    endfunction

    function automatic logic [3:0] model_ff(input logic [15:0] m);
        logic [3:0] f;
        f = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) f = 4'(i);
        return f;
    endfunction

    always_comb po_a = stub(mode, pi_a, rand_tt);
    always_comb po_b = stub(mode, pi_b, rand_tt);

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(expected),
        .probe_in(pi_a), .probe_out(po_a), .busy(busy_a), .res(if_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected),
        .probe_in(pi_b), .probe_out(po_b), .busy(busy_b), .res(if_b)
    );

    logic [3:0]  c_pi;
    logic        c_busy, c_rv, c_match;
    logic [15:0] c_tt, c_mask;
    logic [3:0]  c_ff;
    assign c_pi    = sel ? pi_b : pi_a;
    assign c_busy  = sel ? busy_b : busy_a;
    assign c_rv    = sel ? if_b.result_valid : if_a.result_valid;
    assign c_match = sel ? if_b.match : if_a.match;
    assign c_tt    = sel ? if_b.tt_captured : if_a.tt_captured;
    assign c_mask  = sel ? if_b.mismatch_mask : if_a.mismatch_mask;
    assign c_ff    = sel ? if_b.first_fail : if_a.first_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare: vector index follows elapsed cycles since the start edge, results once valid.
    always @(negedge clk) begin
        if (sweep_on) begin
            automatic int s    = sel ? 1 : 2;
            automatic int last = 16 * s;
            automatic int ev   = (j / s > 15) ? 15 : j / s;
            chk("probe_in", 32'(c_pi), 32'(ev));
            chk("busy", 32'(c_busy), 32'(j < last));
            chk("result_valid", 32'(c_rv), 32'(j >= last));
            if (c_rv) begin
                chk("tt_captured", 32'(c_tt), 32'(m_tt));
                chk("mismatch_mask", 32'(c_mask), 32'(m_mask));
                chk("match", 32'(c_match), 32'(m_match));
                chk("first_fail", 32'(c_ff), 32'(m_ff));
            end
            j++;
        end
    end

    task automatic set_model(input int md, input logic [15:0] ex);
        m_tt    = model_tt(md, rand_tt);
        m_mask  = m_tt ^ ex;
        m_ff    = model_ff(m_mask);
        m_match = (m_mask == 16'h0);
    endtask

    task automatic sweep(input logic s, input int md, input logic [15:0] ex, input int delay, input logic poke);
        int n;
        logic got;
        sel  = s;
        mode = md;
        set_model(md, ex);
        expected = ex;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        j        = 0;
        sweep_on = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            if (poke && n == 5) begin
                start    = 1'b1;
                expected = ~ex;
            end else if (poke && n == 6) begin
                start    = 1'b0;
                expected = ex;
            end
            @(posedge clk); #1;
            n++;
            if (c_rv) got = 1'b1;
        end
        chk("latency_edges", 32'(n), 32'(16 * (s ? 1 : 2)));
        if (!got) begin
            sweep_on = 1'b0;
            return;
        end
        for (int k = 0; k < delay; k++) begin
            start = poke && (k == 2);
            @(posedge clk); #1;
        end
        start = poke;
        ready = 1'b1;
        @(posedge clk); #1;
        ready    = 1'b0;
        start    = 1'b0;
        sweep_on = 1'b0;
        chk("rv_after_ack", 32'(c_rv), 32'd0);
        chk("busy_after_ack", 32'(c_busy), 32'd0);
        chk("probe_idle", 32'(c_pi), 32'd0);
        chk("tt_held", 32'(c_tt), 32'(m_tt));
        chk("mask_held", 32'(c_mask), 32'(m_mask));
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart_busy", 32'(c_busy), 32'd0);
        chk("no_restart_rv", 32'(c_rv), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rv", 32'(if_a.result_valid), 32'd0);
        chk("rst_probe", 32'(pi_a), 32'd0);
        chk("rst_tt", 32'(if_a.tt_captured), 32'd0);
        chk("rst_match", 32'(if_a.match), 32'd1);
        chk("rst_mask", 32'(if_a.mismatch_mask), 32'd0);
        chk("rst_ff", 32'(if_a.first_fail), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);

        chk("model_and4", 32'(model_tt(0, 16'h0)), 32'h8000);
        chk("model_in0", 32'(model_tt(1, 16'h0)), 32'hAAAA);
        chk("model_eq5", 32'(model_tt(3, 16'h0)), 32'h0020);
        chk("model_ff_8e89", 32'(model_ff(16'hFFFF ^ 16'h7176)), 32'd0);
        chk("model_ff_0020", 32'(model_ff(16'h0020)), 32'd5);

        sweep(1'b0, 0, 16'h8000, 0, 1'b0);
        chk("t1_tt", 32'(if_a.tt_captured), 32'h8000);
        chk("t1_match", 32'(if_a.match), 32'd1);
        sweep(1'b0, 1, 16'hAAAA, 1, 1'b0);
        chk("t2_match", 32'(if_a.match), 32'd1);
        sweep(1'b0, 1, 16'hAAAB, 0, 1'b0);
        chk("t2_mask", 32'(if_a.mismatch_mask), 32'h0001);
        chk("t2_ff", 32'(if_a.first_fail), 32'd0);
        sweep(1'b0, 2, 16'h7176, 0, 1'b0);
        chk("t3_tt", 32'(if_a.tt_captured), 32'hFFFF);
        chk("t3_mask", 32'(if_a.mismatch_mask), 32'h8E89);
        chk("t3_match", 32'(if_a.match), 32'd0);
        sweep(1'b0, 3, 16'h0000, 0, 1'b0);
        chk("t3_mask5", 32'(if_a.mismatch_mask), 32'h0020);
        chk("t3_ff5", 32'(if_a.first_fail), 32'd5);

        sweep(1'b0, 1, 16'h5555, 10, 1'b1);

        sel  = 1'b0;
        mode = 0;
        set_model(0, 16'h1234);
        expected = 16'h1234;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        j        = 0;
        sweep_on = 1'b1;
        n = 0;
        while (pi_a != 4'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idx7", 32'(pi_a), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        sweep_on = 1'b0;
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_probe", 32'(pi_a), 32'd0);
        chk("mid_rst_rv", 32'(if_a.result_valid), 32'd0);
        chk("mid_rst_tt", 32'(if_a.tt_captured), 32'd0);
        chk("mid_rst_match", 32'(if_a.match), 32'd1);
        sweep(1'b0, 0, 16'h8000, 0, 1'b0);
        chk("t5_tt", 32'(if_a.tt_captured), 32'h8000);

        sweep(1'b1, 0, 16'h8000, 0, 1'b0);
        chk("t6_tt", 32'(if_b.tt_captured), 32'h8000);
        sweep(1'b1, 3, 16'h0001, 2, 1'b1);
        chk("t6_ff", 32'(if_b.first_fail), 32'd0);

        for (int r = 0; r < 10; r++) begin
            logic [15:0] ex;
            rand_tt = 16'($urandom);
            ex = ($urandom_range(0, 1) == 0) ? rand_tt : 16'($urandom);
            sweep(1'($urandom_range(0, 1)), 4, ex, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential test harness for 4-input combinational gate netlists (NOR/NOT-mapped designs such as the synthesized truth-table circuits).
- Drives every input vector 0..15 into the netlist under test and samples its single output after a settle delay.
- Assembles the observed 16-bit truth table and compares it against an expected hex table.
- Reports match, mismatch mask and first failing index over a valid/ready result handshake.

Parameters:
N_IN, 4, number of netlist inputs; truth-table width TT_W = 2**N_IN (16).
SETTLE, 2, clock cycles each vector is held before its output is sampled; must be >= 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  pulse; begins a sweep, accepted only in IDLE.
expected  in  TT_W  expected truth table; bit i = required output for input vector i; latched on start.
probe_in  out  N_IN  input vector driven to the netlist under test.
probe_out  in  1  netlist output.
busy  out  1  high from the cycle after start acceptance until result_valid rises.
result_valid  out  1  result available; held until accepted.
result_ready  in  1  consumer accepts the result when result_valid && result_ready.
tt_captured  out  TT_W  observed truth table; bit i = probe_out sampled for vector i.
match  out  1  tt_captured == latched expected.
mismatch_mask  out  TT_W  tt_captured XOR latched expected.
first_fail  out  N_IN  index of the lowest set bit of mismatch_mask; 0 when match=1.

Behaviour:
- States: IDLE, DRIVE, REPORT.
- Reset (rst high at an edge, any state) forces all of the following:
  - state=IDLE, probe_in=0, idx=0, settle count=0.
  - tt_captured=0, latched expected=0.
  - busy=0, result_valid=0; therefore match=1, mismatch_mask=0, first_fail=0.
- IDLE:
  - probe_in is held at 0.
  - On start at edge E0: latch expected, clear tt_captured, set idx=0 and settle count=0, go to DRIVE.
- DRIVE:
  - probe_in = idx.
  - The settle count increments each cycle.
  - At the edge where count == SETTLE-1:
    - write probe_out into tt_captured[idx] and reset count to 0;
    - if idx == TT_W-1, go to REPORT; otherwise idx increments and probe_in updates on that edge.
- Timing:
  - Vector i is captured at edge E0+(i+1)*SETTLE.
  - The last capture is at E0+TT_W*SETTLE.
  - result_valid is high in the cycle after that edge, i.e. TT_W*SETTLE+1 cycles after the start cycle (33 for the defaults).
- REPORT:
  - result_valid=1, busy=0, probe_in held at TT_W-1.
  - match, mismatch_mask and first_fail are combinational functions of the registered tt_captured and latched expected, so they are stable while result_valid is high.
  - On result_valid && result_ready, go to IDLE; result_valid drops next cycle.
  - tt_captured and the compare outputs keep their values until the next start.
- start is ignored in DRIVE and REPORT, including a start in the same cycle as the REPORT->IDLE handshake; start must be re-asserted in IDLE.
- expected changes after latch have no effect until the next start.
- idx wraps only through REPORT; there is no free-running wrap.
- probe_out is sampled directly with no synchronizer; the netlist under test is synchronous to clk and must settle within SETTLE cycles.

Decomposition:
- Shared package:
  - state enum {IDLE, DRIVE, REPORT};
  - localparam TT_W;
  - function clog2-based width of the settle counter.
- One sub-module: tt_first_diff, a combinational lowest-set-bit priority encoder (TT_W -> N_IN index plus any-set flag) that drives first_fail.

Test Plan:
1. Stub out = &probe_in, expected=0x8000, SETTLE=2; start -> result_valid exactly 33 cycles after the start cycle; tt_captured=0x8000, match=1, mismatch_mask=0, first_fail=0.
2. Stub out = probe_in[0], expected=0xAAAA -> match=1. Repeat with expected=0xAAAB -> match=0, mismatch_mask=0x0001, first_fail=0.
3. Stub out = 1, expected=0x7176 -> tt_captured=0xFFFF, mismatch_mask=0x8E89, first_fail=0, match=0. Stub out = probe_in==5 with expected=0x0000 -> mismatch_mask=0x0020, first_fail=5.
4. Backpressure: result_ready=0 for 10 cycles after result_valid -> all result outputs stable; start pulses during DRIVE/REPORT ignored; result_ready=1 -> IDLE next cycle with no new sweep.
5. rst at vector idx=7 mid-sweep -> next cycle busy=0, probe_in=0, result_valid=0, tt_captured=0. A fresh start then completes a full 16-vector sweep with correct results.
6. SETTLE=1 -> probe_in steps 0..15 on consecutive cycles; result_valid exactly 17 cycles after the start cycle.
